xcvr_led_status: RTL and testbench

- Builds the 8-bit user-LED vector that feeds the SGPIO slave's LED input, replacing the fixed heartbeat/constant pattern.
- Collects per-lane link-up and error-event status from the 12 F-tile transceiver test channels (3 QSFP cages × 4 lanes).
- Synchronises that status into the 50 MHz system domain and stretches error events so they are visible.
- Shows one cage's lanes at a time: either auto-rotating through cages or fixed by a user switch selection.

---
 rtl/xcvr_led_pkg.sv | 23 ++
 rtl/xcvr_led_status_if.sv | 29 ++
 rtl/xcvr_led_status_lane_err_stretch.sv | 44 ++++
 rtl/xcvr_led_status.sv | 180 ++++++++++++++++++
 tb/tb_xcvr_led_status.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/xcvr_led_pkg.sv
// Shared constants and types for the transceiver status LED block.
// LED bit map, page-mode encoding and page FSM states.
package xcvr_led_pkg;

  localparam int LANES_PER_CAGE = 4;

  localparam int LED_LANE_LSB = 0;
  localparam int LED_PAGE_LSB = 4;
  localparam int LED_ALLUP    = 6;
  localparam int LED_HB       = 7;

  localparam logic [1:0] PAGE_AUTO = 2'd0;

  typedef enum logic {
    AUTO,
    FIXED
  } page_st_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xcvr_led_status_if.sv
// Status inputs and LED outputs of the transceiver status LED block.
// Master drives lane status and switch; slave returns the LED vector.
interface xcvr_led_status_if #(
  parameter int NUM_CH = 12
) ();

  logic [NUM_CH-1:0] i_link_up;
  logic [NUM_CH-1:0] i_err_toggle;
  logic [1:0]        i_page_sel;
  logic [7:0]        o_led;
  logic [1:0]        o_page;

  modport master (
    output i_link_up,
    output i_err_toggle,
    output i_page_sel,
    input  o_led,
    input  o_page
  );

  modport slave (
    input  i_link_up,
    input  i_err_toggle,
    input  i_page_sel,
    output o_led,
    output o_page
  );

endinterface

// File: rtl/xcvr_led_status_lane_err_stretch.sv
// One lane: synchronise link/error status, detect error toggles and
// hold the error indication for a number of base ticks.
module lane_err_stretch #(
  parameter int STRETCH_TICKS = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic link_up,
  input  logic err_toggle,
  output logic link_s,
  output logic err_active
);

  localparam int CW = $clog2(STRETCH_TICKS + 1);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH_TICKS);

  logic [1:0]    link_q;
  logic [2:0]    err_q;
  logic [CW-1:0] cnt;
  logic          evt;

  assign evt        = err_q[1] ^ err_q[2];
  assign link_s     = link_q[1];
  assign err_active = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= '0;
      err_q  <= '0;
      cnt    <= '0;
    end else begin
      link_q <= {link_q[0], link_up};
      err_q  <= {err_q[1:0], err_toggle};
      // a fresh event always reloads, even on a tick
      if (evt) begin
        cnt <= LOAD;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/xcvr_led_status.sv
// User-LED status vector for the SGPIO slave: per-lane link/error of one
// QSFP cage at a time, page index, all-lanes-up and heartbeat.
module xcvr_led_status
  import xcvr_led_pkg::*;
#(
  parameter int NUM_CAGE      = 3,
  parameter int TICK_DIV      = 50000,
  parameter int STRETCH_TICKS = 50,
  parameter int BLINK_TICKS   = 100,
  parameter int PAGE_TICKS    = 2000,
  parameter int HB_TICKS      = 500
) (
  input logic i_clk,
  input logic i_rstn,
  xcvr_led_status_if.slave bus
);

  localparam int NUM_CH = LANES_PER_CAGE * NUM_CAGE;
  localparam int TW = cw(TICK_DIV);
  localparam int BW = cw(BLINK_TICKS);
  localparam int HW = cw(HB_TICKS);
  localparam int DW = cw(PAGE_TICKS);

  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HLAST = HW'(HB_TICKS - 1);
  localparam logic [DW-1:0] DLAST = DW'(PAGE_TICKS - 1);
  localparam logic [1:0]    LAST  = 2'(NUM_CAGE - 1);
  localparam logic [2:0]    NC    = 3'(NUM_CAGE);

  logic [NUM_CH-1:0] link_s;
  logic [NUM_CH-1:0] err_act;

  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink, blink_nxt;
  logic [HW-1:0] hb_cnt, hb_cnt_nxt;
  logic          hb, hb_nxt;

  logic [1:0]    sel_s1, sel_s2, sel_idx;
  logic          sel_fixed;
  page_st_e      state, state_nxt;
  logic [1:0]    page, page_nxt, rot_page;
  logic [DW-1:0] dwell, dwell_nxt, rot_dwell;

  logic [3:0]    lane_q, lane_nxt;
  logic          allup_q;

  assign tick = (tick_cnt == TLAST);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    lane_err_stretch #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_lane (
      .clk        (i_clk),
      .rst_n      (i_rstn),
      .tick       (tick),
      .link_up    (bus.i_link_up[i]),
      .err_toggle (bus.i_err_toggle[i]),
      .link_s     (link_s[i]),
      .err_active (err_act[i])
    );
  end

  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_nxt     = blink;
    hb_cnt_nxt    = hb_cnt;
    hb_nxt        = hb;
    if (tick) begin
      if (blink_cnt == BLAST) begin
        blink_cnt_nxt = '0;
        blink_nxt     = ~blink;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
      if (hb_cnt == HLAST) begin
        hb_cnt_nxt = '0;
        hb_nxt     = ~hb;
      end else begin
        hb_cnt_nxt = hb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sel_fixed = (sel_s2 != PAGE_AUTO) && ({1'b0, sel_s2} <= NC);
    sel_idx   = sel_s2 - 2'd1;
    rot_page  = page;
    rot_dwell = dwell;
    if (tick) begin
      if (dwell == DLAST) begin
        rot_dwell = '0;
        rot_page  = (page == LAST) ? 2'd0 : page + 2'd1;
      end else begin
        rot_dwell = dwell + 1'b1;
      end
    end
    state_nxt = state;
    page_nxt  = page;
    dwell_nxt = dwell;
    unique case (state)
      AUTO: begin
        if (sel_fixed) begin
          state_nxt = FIXED;
          page_nxt  = sel_idx;
          dwell_nxt = '0;
        end else begin
          page_nxt  = rot_page;
          dwell_nxt = rot_dwell;
        end
      end
      FIXED: begin
        // dwell is parked at 0 here, so rotation resumes with a full dwell
        if (sel_fixed) begin
          page_nxt  = sel_idx;
          dwell_nxt = '0;
        end else begin
          state_nxt = AUTO;
          page_nxt  = rot_page;
          dwell_nxt = rot_dwell;
        end
      end
    endcase
  end

  always_comb begin
    lane_nxt = '0;
    for (int l = 0; l < LANES_PER_CAGE; l++) begin
      for (int p = 0; p < NUM_CAGE; p++) begin
        if (page_nxt == 2'(p)) begin
          lane_nxt[l] = link_s[p*LANES_PER_CAGE+l] &
                        (~err_act[p*LANES_PER_CAGE+l] | blink_nxt);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      hb_cnt    <= '0;
      hb        <= 1'b0;
      sel_s1    <= '0;
      sel_s2    <= '0;
      state     <= AUTO;
      page      <= '0;
      dwell     <= '0;
      lane_q    <= '0;
      allup_q   <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      blink_cnt <= blink_cnt_nxt;
      blink     <= blink_nxt;
      hb_cnt    <= hb_cnt_nxt;
      hb        <= hb_nxt;
      sel_s1    <= bus.i_page_sel;
      sel_s2    <= sel_s1;
      state     <= state_nxt;
      page      <= page_nxt;
      dwell     <= dwell_nxt;
      lane_q    <= lane_nxt;
      allup_q   <= &link_s;
    end
  end

  always_comb begin
    bus.o_led = '0;
    bus.o_led[LED_LANE_LSB +: 4] = lane_q;
    bus.o_led[LED_PAGE_LSB +: 2] = page;
    bus.o_led[LED_ALLUP]         = allup_q;
    bus.o_led[LED_HB]            = hb;
  end

  assign bus.o_page = page;

endmodule

// File: tb/tb_xcvr_led_status.sv
// Scoreboard bench for xcvr_led_status: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_xcvr_led_status;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n    = 0;
  int   base = 0;
  int   tests  = 0;
  int   failed = 0;
  bit   flush  = 1'b0;

  typedef struct {
    int         when;
    int         dut;
    logic [7:0] mask;
    logic [7:0] led;
    bit         cp;
    logic [1:0] page;
    string      name;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] got_led;
  logic [1:0] got_page;

  xcvr_led_status_if #(.NUM_CH(12)) bus1 ();
  xcvr_led_status_if #(.NUM_CH(8))  bus2 ();

  xcvr_led_status #(
    .NUM_CAGE(3), .TICK_DIV(4), .STRETCH_TICKS(3),
    .BLINK_TICKS(1), .PAGE_TICKS(5), .HB_TICKS(2)
  ) dut1 (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus1)
  );

  xcvr_led_status #(
    .NUM_CAGE(2), .TICK_DIV(4), .STRETCH_TICKS(3),
    .BLINK_TICKS(1), .PAGE_TICKS(5), .HB_TICKS(2)
  ) dut2 (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n <= n + 1;

  task automatic push(input int dut, input int rel,
                      input logic [7:0] mask, input logic [7:0] led,
                      input bit cp, input logic [1:0] page,
                      input string name);
    exp_t e;
    int   i;
    e.when = base + rel;
    e.dut  = dut;
    e.mask = mask;
    e.led  = led;
    e.cp   = cp;
    e.page = page;
    e.name = name;
    i = q.size();
    while (i > 0 && q[i-1].when > e.when) i--;
    q.insert(i, e);
  endtask

  task automatic at(input int rel);
    while (n < base + rel) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus1.i_link_up    = '0;
    bus1.i_err_toggle = '0;
    bus1.i_page_sel   = '0;
    bus2.i_link_up    = '0;
    bus2.i_err_toggle = '0;
    for (int k = 1; k <= 3; k++) begin
      push(1, n + k - base, 8'hFF, 8'h00, 1'b1, 2'd0, "rst_d1");
      push(2, n + k - base, 8'hFF, 8'h00, 1'b1, 2'd0, "rst_d2");
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base = n;
  endtask

  task automatic fresh();
    push(1, 1,  8'hFF, 8'h00, 1'b1, 2'd0, "fresh_r1");
    push(1, 7,  8'hFF, 8'h00, 1'b1, 2'd0, "hb_pre");
    push(1, 8,  8'hFF, 8'h80, 1'b1, 2'd0, "hb_first");
    push(1, 15, 8'hFF, 8'h80, 1'b1, 2'd0, "hb_hold");
    push(1, 16, 8'hFF, 8'h00, 1'b1, 2'd0, "hb_second");
    push(1, 19, 8'hFF, 8'h00, 1'b1, 2'd0, "page0_end");
    push(1, 20, 8'hFF, 8'h10, 1'b1, 2'd1, "page_adv");
  endtask

  task automatic pg(input int dut, input int rel, input logic [1:0] p,
                    input string name);
    logic [7:0] v;
    v = {2'b00, p, 4'h0};
    push(dut, rel, 8'h30, v, 1'b1, p, name);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && (flush || q[0].when <= n)) begin
      cur = q.pop_front();
      tests++;
      got_led  = (cur.dut == 1) ? bus1.o_led  : bus2.o_led;
      got_page = (cur.dut == 1) ? bus1.o_page : bus2.o_page;
      if (cur.when != n) begin
        failed++;
        $display("FAIL %s: sample for cycle %0d not taken (now %0d)",
                 cur.name, cur.when, n);
      end else if ((((got_led ^ cur.led) & cur.mask) != 8'h00) ||
                   (cur.cp && (got_page != cur.page))) begin
        failed++;
        $display("FAIL %s: dut%0d led=%h page=%0d, expected led=%h mask=%h page=%0d",
                 cur.name, cur.dut, got_led, got_page,
                 cur.led, cur.mask, cur.page);
      end
    end
  end

  initial begin
    bus1.i_link_up    = '0;
    bus1.i_err_toggle = '0;
    bus1.i_page_sel   = '0;
    bus2.i_link_up    = '0;
    bus2.i_err_toggle = '0;
    bus2.i_page_sel   = 2'd3;

    do_reset();
    fresh();
    at(22);

    do_reset();
    bus1.i_page_sel = 2'd2;
    bus1.i_link_up  = 12'h0F0;
    push(1, 2,  8'hFF, 8'h00, 1'b1, 2'd0, "fixed_pre");
    push(1, 3,  8'hFF, 8'h1F, 1'b1, 2'd1, "fixed_page");
    push(1, 8,  8'hFF, 8'h9F, 1'b1, 2'd1, "fixed_hb");
    push(1, 12, 8'hFF, 8'h9F, 1'b1, 2'd1, "allup_pre");
    push(1, 13, 8'hFF, 8'hDF, 1'b1, 2'd1, "allup_3cyc");
    push(1, 23, 8'hFF, 8'h5F, 1'b1, 2'd1, "err_pre");
    push(1, 24, 8'hFF, 8'hDD, 1'b1, 2'd1, "blink_lo1");
    push(1, 27, 8'hFF, 8'hDD, 1'b1, 2'd1, "blink_lo2");
    push(1, 28, 8'hFF, 8'hDF, 1'b1, 2'd1, "blink_hi");
    push(1, 32, 8'hFF, 8'h5D, 1'b1, 2'd1, "blink_last");
    push(1, 33, 8'hFF, 8'h5F, 1'b1, 2'd1, "stretch_end");
    push(1, 50, 8'hFF, 8'h5D, 1'b1, 2'd1, "blink2_lo");
    push(1, 56, 8'hFF, 8'hDD, 1'b1, 2'd1, "reload_held");
    push(1, 61, 8'hFF, 8'hDF, 1'b1, 2'd1, "reload_end");
    at(10); bus1.i_link_up = 12'hFFF;
    at(20); bus1.i_err_toggle[5] = ~bus1.i_err_toggle[5];
    at(40); bus1.i_err_toggle[5] = ~bus1.i_err_toggle[5];
    at(46); bus1.i_err_toggle[5] = ~bus1.i_err_toggle[5];
    at(63);

    do_reset();
    bus1.i_page_sel = 2'd0;
    pg(1, 19, 2'd0, "auto_p0");
    pg(1, 20, 2'd1, "auto_p1");
    pg(1, 39, 2'd1, "auto_p1_end");
    pg(1, 40, 2'd2, "auto_p2");
    pg(1, 59, 2'd2, "auto_p2_end");
    pg(1, 60, 2'd0, "auto_wrap");
    pg(1, 64, 2'd0, "auto_mid");
    pg(1, 67, 2'd0, "sel3_pre");
    pg(1, 68, 2'd2, "sel3_fixed");
    pg(1, 77, 2'd2, "resume_start");
    pg(1, 95, 2'd2, "resume_dwell");
    pg(1, 96, 2'd0, "resume_adv");
    pg(2, 19, 2'd0, "nc2_p0");
    pg(2, 20, 2'd1, "nc2_p1");
    pg(2, 39, 2'd1, "nc2_p1_end");
    pg(2, 40, 2'd0, "nc2_wrap");
    pg(2, 59, 2'd0, "nc2_p0_end");
    pg(2, 60, 2'd1, "nc2_p1_again");
    at(65); bus1.i_page_sel = 2'd3;
    at(75); bus1.i_page_sel = 2'd0;
    at(98);

    do_reset();
    bus1.i_page_sel = 2'd0;
    bus1.i_link_up  = 12'hFFF;
    push(1, 15, 8'hFF, 8'hCF, 1'b1, 2'd0, "mid_blink_hi");
    push(1, 17, 8'hFF, 8'h4D, 1'b1, 2'd0, "mid_blink_lo");
    at(10); bus1.i_err_toggle[1] = 1'b1;
    at(18);
    do_reset();
    fresh();
    at(22);

    repeat (200) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    flush = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
